sensor_window_capture: RTL and testbench
========================================

# sensor_window_capture

Upstream capture stage for the VGA/LCD adaptive control path. Samples the ten raw timing-error sensor flags, counts events per sensor over a fixed evaluation window, and at window end publishes a thresholded, stable sensor vector. The combinational sensor-group control logic consumes this vector as its `sensorN_level0` inputs. The vector is published with a valid/ack handshake and overrun detection.

## Interface
- `NUM_SENSORS`, 10: number of sensor lanes.
- `WIN_CYCLES`, 256: window length in cycles; legal range 2..65536.
- `CNT_W`, 4: width of each per-sensor saturating event counter.
- `THRESH`, 1: minimum event count in a window that sets the published bit; legal range 1..2^CNT_W-1.
- `clk`  in  1: single clock; all state on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `en`  in  1: capture enable.
- `sensor_raw`  in  NUM_SENSORS: raw per-sensor error flags, one event per high cycle.
- `sensor_ack`  in  1: consumer accepts the published vector.
- `ovr_clr`  in  1: clears the sticky overrun flag.
- `sensor_level0`  out  NUM_SENSORS: published thresholded vector; bit i feeds `sensor<i>_level0`.
- `sensor_valid`  out  1: published vector not yet acknowledged.
- `overrun`  out  1: sticky; a published vector was overwritten unacknowledged.
- `win_cnt`  out  clog2(WIN_CYCLES): current window position, for debug.

## Operation
- States: IDLE and ACCUM.
  - IDLE→ACCUM when `en`=1.
  - ACCUM→IDLE when `en`=0.
- Leaving ACCUM: window counter and all event counters clear to 0. `sensor_level0`, `sensor_valid` and `overrun` hold their values. A partial window never publishes.
- ACCUM, each cycle: for each i with `sensor_raw[i]`=1, `cnt[i]` increments, saturating at 2^CNT_W-1. `win_cnt` increments.
- ACCUM, cycle where `win_cnt`=WIN_CYCLES-1 (window end):
  - `sensor_level0[i]` <= ((cnt[i] + sensor_raw[i]) >= THRESH). The sum is computed in CNT_W+1 bits, so the end cycle's event is included.
  - `sensor_valid` <= 1.
  - `win_cnt` and all `cnt` wrap to 0. The next window starts the following cycle with no gap.
- Handshake:
  - The vector is consumed when `sensor_valid`=1 and `sensor_ack`=1 on the same edge; `sensor_valid` falls on the next edge.
  - `sensor_ack` while `sensor_valid`=0 is ignored.
- Window end while `sensor_valid`=1 and `sensor_ack`=0: the vector is overwritten, `sensor_valid` stays 1, and `overrun` <= 1.
- Window end with `sensor_ack`=1 on the same cycle: the new vector loads, `sensor_valid` stays 1, `overrun` is unchanged.
- `overrun` clears only on `ovr_clr`=1 or `rst`. If `ovr_clr` and a new overrun occur on the same cycle, the set wins.

## Timing
- Reset values: `sensor_level0`=0, `sensor_valid`=0, `overrun`=0, `win_cnt`=0, all `cnt`=0, state IDLE.
- Reset mid-window discards the partial window and any pending unacknowledged vector.
- First window starts on the first edge with `en`=1. `win_cnt` is 0 in that cycle and a `sensor_raw` pulse in that cycle counts.
- Latency: publish is registered one edge after the window-end cycle. With `en` high continuously from cycle 0, `sensor_valid` first rises at the edge ending cycle WIN_CYCLES-1.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SENSOR_SYNC_EN` defined:
  - `sensor_raw` passes through a two-flop synchronizer per lane before counting; synchronizer flops reset to 0.
  - Events are attributed to the window two cycles later than their raw arrival.
- `SENSOR_SYNC_EN` undefined: `sensor_raw` is counted directly, with zero added latency; sources must be synchronous to `clk`.

## Structure
- Shared package `sensor_cap_pkg`:
  - `sensor_vec_t` (NUM_SENSORS-bit vector).
  - State enum `cap_state_e` {IDLE, ACCUM}.
  - Default constants for NUM_SENSORS, WIN_CYCLES, CNT_W, THRESH.
- One sub-module, `sensor_evt_counter`: one lane's saturating CNT_W counter plus threshold compare. Instantiated NUM_SENSORS times via generate.
- Window counter, FSM, handshake and overrun logic live in the top.

## Test plan
All scenarios use WIN_CYCLES=8, THRESH=2, CNT_W=4, `SENSOR_SYNC_EN` undefined, `en` held high.
- Threshold: pulse `sensor_raw[3]` twice and `sensor_raw[7]` once in window 0 → at publish `sensor_level0`=10'h008, `sensor_valid`=1.
- Saturation and end-cycle event: `sensor_raw[0]` high for all 8 cycles, `sensor_raw[1]` high only in cycle 7 → bit 0=1, `cnt[0]` does not exceed 15, bit 1=0. With THRESH=1, bit 1=1.
- Overrun: no ack for two windows → second vector overwrites, `overrun`=1. `ovr_clr` pulse → `overrun`=0.
- Simultaneous ack and publish: ack in window 1's end cycle → new vector loads, `sensor_valid` stays 1, `overrun` stays 0.
- Abort: `en` dropped at `win_cnt`=5 after 3 events on lane 2 → no publish. Re-enable and give 1 event on lane 2 in a full window → bit 2=0.
- Reset mid-window with `sensor_valid`=1 → all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/sensor_cap_pkg.sv
// Shared types and default parameters for the sensor window capture block.
// Build option: SENSOR_SYNC_EN adds a two-flop synchronizer on each raw sensor lane.
package sensor_cap_pkg;

    localparam int NUM_SENSORS_DEF = 10;
    localparam int WIN_CYCLES_DEF  = 256;
    localparam int CNT_W_DEF       = 4;
    localparam int THRESH_DEF      = 1;

    typedef logic [NUM_SENSORS_DEF-1:0] sensor_vec_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } cap_state_e;

endpackage

// File: rtl/sensor_evt_counter.sv
// One sensor lane: saturating event counter plus threshold compare.
// hit includes the current cycle's event, so the window-end cycle is counted.
module sensor_evt_counter
    import sensor_cap_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic cnt_en,
    input  logic raw,
    output logic hit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   sum;

    assign sum = {1'b0, cnt} + {{CNT_W{1'b0}}, raw};
    assign hit = (sum >= (CNT_W+1)'(THRESH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt_en && raw && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sensor_window_capture.sv
// Counts per-sensor events over a fixed window and publishes a thresholded vector
// with valid/ack handshake and sticky overrun. Build option: SENSOR_SYNC_EN.
module sensor_window_capture
    import sensor_cap_pkg::*;
#(
    parameter int NUM_SENSORS = NUM_SENSORS_DEF,
    parameter int WIN_CYCLES  = WIN_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int THRESH      = THRESH_DEF,
    localparam int WW         = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NUM_SENSORS-1:0] sensor_raw,
    input  logic                   sensor_ack,
    input  logic                   ovr_clr,
    output logic [NUM_SENSORS-1:0] sensor_level0,
    output logic                   sensor_valid,
    output logic                   overrun,
    output logic [WW-1:0]          win_cnt
);

    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);

    logic [NUM_SENSORS-1:0] sensor_evt;
    logic [NUM_SENSORS-1:0] lane_hit;
    logic                   win_end;
    cap_state_e             state;

`ifdef SENSOR_SYNC_EN
    logic [NUM_SENSORS-1:0] sync_q1;
    logic [NUM_SENSORS-1:0] sync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sensor_raw;
            sync_q2 <= sync_q1;
        end
    end

    assign sensor_evt = sync_q2;
`else
    assign sensor_evt = sensor_raw;
`endif

    // The cycle that sees en=1 is already window cycle 0, even from IDLE.
    assign win_end = en && (win_cnt == WIN_LAST);

    for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_lane
        sensor_evt_counter #(
            .CNT_W  (CNT_W),
            .THRESH (THRESH)
        ) u_cnt (
            .clk    (clk),
            .rst    (rst),
            .clr    (!en || win_end),
            .cnt_en (en),
            .raw    (sensor_evt[i]),
            .hit    (lane_hit[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            win_cnt       <= '0;
            sensor_level0 <= '0;
            sensor_valid  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (en)  state <= ACCUM;
                ACCUM:   if (!en) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (!en || win_end) begin
                win_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + 1'b1;
            end

            if (win_end) begin
                sensor_level0 <= lane_hit;
                sensor_valid  <= 1'b1;
            end else if (sensor_valid && sensor_ack) begin
                sensor_valid  <= 1'b0;
            end

            // A fresh overrun outranks a same-cycle clear.
            if (win_end && sensor_valid && !sensor_ack) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sensor_window_capture.sv
// Directed bench for sensor_window_capture with an 8-cycle window; two extra
// instances cover THRESH=1 and a 2-bit saturating counter on the same stimulus.
module tb_sensor_window_capture;
    import sensor_cap_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    sensor_vec_t sensor_raw;
    logic        sensor_ack;
    logic        ovr_clr;

    sensor_vec_t level, level_t1, level_sat;
    logic        valid, valid_t1, valid_sat;
    logic        ovr, ovr_t1, ovr_sat;
    logic [2:0]  win_cnt, win_cnt_t1, win_cnt_sat;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    sensor_window_capture #(.NUM_SENSORS(10), .WIN_CYCLES(8), .CNT_W(4), .THRESH(2)) dut (
        .clk(clk), .rst(rst), .en(en), .sensor_raw(sensor_raw), .sensor_ack(sensor_ack),
        .ovr_clr(ovr_clr), .sensor_level0(level), .sensor_valid(valid), .overrun(ovr),
        .win_cnt(win_cnt));

    sensor_window_capture #(.NUM_SENSORS(10), .WIN_CYCLES(8), .CNT_W(4), .THRESH(1)) dut_t1 (
        .clk(clk), .rst(rst), .en(en), .sensor_raw(sensor_raw), .sensor_ack(sensor_ack),
        .ovr_clr(ovr_clr), .sensor_level0(level_t1), .sensor_valid(valid_t1), .overrun(ovr_t1),
        .win_cnt(win_cnt_t1));

    sensor_window_capture #(.NUM_SENSORS(10), .WIN_CYCLES(8), .CNT_W(2), .THRESH(3)) dut_sat (
        .clk(clk), .rst(rst), .en(en), .sensor_raw(sensor_raw), .sensor_ack(sensor_ack),
        .ovr_clr(ovr_clr), .sensor_level0(level_sat), .sensor_valid(valid_sat), .overrun(ovr_sat),
        .win_cnt(win_cnt_sat));

    task automatic step(input sensor_vec_t r);
        sensor_raw = r;
        @(posedge clk);
        #1;
        sensor_raw = '0;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step('0);
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; sensor_raw = '0; sensor_ack = 1'b0; ovr_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt += 4;
        if (level !== 10'h000) begin err_cnt++; $display("FAIL reset_level got %h want 000", level); end
        if (valid !== 1'b0)    begin err_cnt++; $display("FAIL reset_valid got %b want 0", valid); end
        if (ovr !== 1'b0)      begin err_cnt++; $display("FAIL reset_overrun got %b want 0", ovr); end
        if (win_cnt !== 3'd0)  begin err_cnt++; $display("FAIL reset_win_cnt got %0d want 0", win_cnt); end
    endtask

    task automatic test_threshold();
        do_reset();
        en = 1'b1;
        step('0); step(10'h008); step(10'h080); step('0); step(10'h008); step('0); step('0);
        vec_cnt += 2;
        if (win_cnt !== 3'd7) begin err_cnt++; $display("FAIL thr_win_cnt got %0d want 7", win_cnt); end
        if (valid !== 1'b0)   begin err_cnt++; $display("FAIL thr_early_valid got %b want 0", valid); end
        step('0);
        vec_cnt += 3;
        if (valid !== 1'b1)    begin err_cnt++; $display("FAIL thr_valid got %b want 1", valid); end
        if (level !== 10'h008) begin err_cnt++; $display("FAIL thr_level got %h want 008", level); end
        if (win_cnt !== 3'd0)  begin err_cnt++; $display("FAIL thr_wrap got %0d want 0", win_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 6; k++) step(10'h005);
        step(10'h001);
        step(10'h003);
        vec_cnt += 3;
        if (level !== 10'h005)     begin err_cnt++; $display("FAIL sat_level_thr2 got %h want 005", level); end
        if (level_t1 !== 10'h007)  begin err_cnt++; $display("FAIL sat_level_thr1 got %h want 007", level_t1); end
        if (level_sat !== 10'h005) begin err_cnt++; $display("FAIL sat_level_cnt2 got %h want 005", level_sat); end
    endtask

    task automatic test_overrun();
        do_reset();
        en = 1'b1;
        steps(8);
        vec_cnt += 2;
        if (valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_first_valid got %b want 1", valid); end
        if (ovr !== 1'b0)   begin err_cnt++; $display("FAIL ovr_first_ovr got %b want 0", ovr); end
        step(10'h020); step(10'h020); steps(6);
        vec_cnt += 3;
        if (ovr !== 1'b1)      begin err_cnt++; $display("FAIL ovr_set got %b want 1", ovr); end
        if (valid !== 1'b1)    begin err_cnt++; $display("FAIL ovr_valid got %b want 1", valid); end
        if (level !== 10'h020) begin err_cnt++; $display("FAIL ovr_level got %h want 020", level); end
        ovr_clr = 1'b1; step('0); ovr_clr = 1'b0;
        vec_cnt += 1;
        if (ovr !== 1'b0) begin err_cnt++; $display("FAIL ovr_clr got %b want 0", ovr); end
        steps(6);
        ovr_clr = 1'b1; step('0); ovr_clr = 1'b0;
        vec_cnt += 1;
        if (ovr !== 1'b1) begin err_cnt++; $display("FAIL ovr_set_beats_clr got %b want 1", ovr); end
    endtask

    task automatic test_ack_at_publish();
        do_reset();
        en = 1'b1;
        step(10'h008); step(10'h008); steps(6);
        step(10'h200); step(10'h200); steps(5);
        sensor_ack = 1'b1; step('0); sensor_ack = 1'b0;
        vec_cnt += 3;
        if (valid !== 1'b1)    begin err_cnt++; $display("FAIL ack_pub_valid got %b want 1", valid); end
        if (ovr !== 1'b0)      begin err_cnt++; $display("FAIL ack_pub_ovr got %b want 0", ovr); end
        if (level !== 10'h200) begin err_cnt++; $display("FAIL ack_pub_level got %h want 200", level); end
        sensor_ack = 1'b1; step('0); sensor_ack = 1'b0;
        vec_cnt += 1;
        if (valid !== 1'b0) begin err_cnt++; $display("FAIL ack_consume got %b want 0", valid); end
        sensor_ack = 1'b1; step('0); sensor_ack = 1'b0;
        vec_cnt += 2;
        if (valid !== 1'b0) begin err_cnt++; $display("FAIL ack_idle_valid got %b want 0", valid); end
        if (ovr !== 1'b0)   begin err_cnt++; $display("FAIL ack_idle_ovr got %b want 0", ovr); end
    endtask

    task automatic test_abort();
        do_reset();
        en = 1'b1;
        step(10'h004); step(10'h004); step(10'h004); steps(2);
        vec_cnt += 1;
        if (win_cnt !== 3'd5) begin err_cnt++; $display("FAIL abort_pos got %0d want 5", win_cnt); end
        en = 1'b0;
        step('0);
        vec_cnt += 2;
        if (win_cnt !== 3'd0) begin err_cnt++; $display("FAIL abort_win_clr got %0d want 0", win_cnt); end
        if (valid !== 1'b0)   begin err_cnt++; $display("FAIL abort_valid got %b want 0", valid); end
        steps(4);
        vec_cnt += 1;
        if (valid !== 1'b0) begin err_cnt++; $display("FAIL abort_no_pub got %b want 0", valid); end
        en = 1'b1;
        step(10'h004); steps(6);
        vec_cnt += 1;
        if (valid !== 1'b0) begin err_cnt++; $display("FAIL reen_early got %b want 0", valid); end
        step('0);
        vec_cnt += 2;
        if (valid !== 1'b1)    begin err_cnt++; $display("FAIL reen_valid got %b want 1", valid); end
        if (level !== 10'h000) begin err_cnt++; $display("FAIL reen_level got %h want 000", level); end
    endtask

    task automatic test_async_reset();
        do_reset();
        en = 1'b1;
        step(10'h008); step(10'h008); steps(6);
        steps(8);
        steps(3);
        vec_cnt += 2;
        if (valid !== 1'b1) begin err_cnt++; $display("FAIL arst_pre_valid got %b want 1", valid); end
        if (ovr !== 1'b1)   begin err_cnt++; $display("FAIL arst_pre_ovr got %b want 1", ovr); end
        rst = 1'b1;
        #1;
        vec_cnt += 4;
        if (valid !== 1'b0)    begin err_cnt++; $display("FAIL arst_valid got %b want 0", valid); end
        if (level !== 10'h000) begin err_cnt++; $display("FAIL arst_level got %h want 000", level); end
        if (ovr !== 1'b0)      begin err_cnt++; $display("FAIL arst_ovr got %b want 0", ovr); end
        if (win_cnt !== 3'd0)  begin err_cnt++; $display("FAIL arst_win_cnt got %0d want 0", win_cnt); end
        #2;
        rst = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sensor_raw = '0; sensor_ack = 1'b0; ovr_clr = 1'b0;
        test_reset();
        test_threshold();
        test_saturation();
        test_overrun();
        test_ack_at_publish();
        test_abort();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
